bbox_frame_ctrl: RTL and testbench
==================================

// Module: bbox_frame_ctrl
// PURPOSE
//  Frame sequencer for the bounding-box engine. Accepts a byte stream (BGR-ordered pixel bytes, bottom row first)
//  from the HPS bridge, clears the engine before each frame, forwards bytes as write strobes and counts them.
//  It also detects frame end, latches the engine's {xMin,xMax,yMin,yMax} word and reports done/busy to software.
// PARAMETERS
//  WIDTH        100    pixels per row
//  HEIGHT       100    rows per frame
//  BPP          3      bytes per pixel; TOTAL = WIDTH*HEIGHT*BPP (30000 default)
//  CW           15     byte-counter width, >= $clog2(TOTAL+1)
//  STALL_CYCLES 1024   idle-input limit in STREAM (used only with BBOX_STALL_TIMEOUT_EN)
// PORTS
//  CLOCK_50     in   1   system clock
//  reset_n      in   1   synchronous, active-low reset
//  start        in   1   1-cycle pulse: begin new frame
//  abort        in   1   1-cycle pulse: cancel frame
//  s_data       in   8   stream byte
//  s_valid      in   1   s_data valid
//  s_ready      out  1   controller accepts byte this cycle
//  box_clr      out  1   1-cycle clear pulse to engine
//  box_wr_en    out  1   engine write strobe
//  box_byte     out  8   byte to engine
//  box_result   in   32  engine output {xMin,xMax,yMin,yMax}
//  result       out  32  latched frame result
//  byte_count   out  CW  bytes accepted this frame
//  busy         out  1   high in CLEAR/STREAM/FLUSH
//  done         out  1   high in DONE
//  stall_err    out  1   high in ERR (macro only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state IDLE; s_ready,box_clr,box_wr_en,busy,done,stall_err=0; result=0; byte_count=0.
//  - States: IDLE, CLEAR, STREAM, FLUSH, DONE (+ERR with macro). Registered state; outputs decoded from state.
//  - IDLE: start -> CLEAR. DONE: start -> CLEAR (done drops same edge). start ignored in CLEAR/STREAM/FLUSH.
//  - CLEAR: exactly 1 cycle; box_clr=1; byte_count<=0; -> STREAM.
//  - STREAM: s_ready=1. Transfer = s_valid & s_ready. box_wr_en=transfer, box_byte=s_data (combinational, 0 latency).
//    Each transfer: byte_count<=byte_count+1. Transfer with byte_count==TOTAL-1 -> FLUSH; s_ready low next cycle.
//  - FLUSH: 1 cycle, no strobes (engine output settles); result<=box_result at end of FLUSH; -> DONE.
//  - DONE: done=1, result held; no transfers accepted; byte_count holds TOTAL.
//  - abort in CLEAR/STREAM/FLUSH: -> IDLE next edge, box_clr=1 for that 1 cycle (from registered abort flag),
//    result unchanged, byte_count held. abort in IDLE/DONE: no effect. abort+start same cycle: abort wins.
//  - Counter never wraps: STREAM exits exactly at TOTAL; TOTAL > 2^CW-1 is illegal (elaboration $error).
//  - reset_n mid-frame overrides all: reset values next edge; engine is reset by its own reset_n.
// CONFIGURATION
//  BBOX_STALL_TIMEOUT_EN defined: in STREAM, an idle counter counts consecutive cycles with s_valid=0 and resets
//    on any transfer. At STALL_CYCLES -> ERR: stall_err=1, s_ready=0, result unchanged. start -> CLEAR, abort -> IDLE.
//  Undefined: no idle counter, no ERR state, stall_err tied 0; STREAM waits indefinitely.
// TESTING
//  1. start, 30000 bytes, s_valid always 1 -> 30000 box_wr_en pulses, s_ready 0 the cycle after the last byte,
//     done=1 2 cycles after the last transfer, result==box_result sampled in FLUSH.
//  2. Same frame, s_valid random 50% -> byte_count increments only on transfers; done after the 30000th transfer.
//  3. start pulsed at byte 500 of STREAM -> ignored; box_clr stays 0; frame completes normally.
//  4. abort at byte 1000 -> IDLE next edge, 1-cycle box_clr, done=0, result keeps previous frame value.
//  5. reset_n low at byte 12000 -> next edge all outputs at reset values; new start runs a clean full frame.
//  6. (BBOX_STALL_TIMEOUT_EN, STALL_CYCLES=16) s_valid dropped after byte 500 -> stall_err=1 after 16 idle cycles;
//     start -> CLEAR, then a full frame completes.

Source files
------------

// File: rtl/bbox_frame_ctrl.sv
// rtl/bbox_frame_ctrl.sv - frame sequencer: clear engine, stream TOTAL bytes, latch bounding-box result
// Optional stall watchdog enabled by defining BBOX_STALL_TIMEOUT_EN.
module bbox_frame_ctrl #(
    parameter int WIDTH        = 100,
    parameter int HEIGHT       = 100,
    parameter int BPP          = 3,
    parameter int CW           = 15,
    parameter int STALL_CYCLES = 1024
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          box_clr,
    output logic          box_wr_en,
    output logic [7:0]    box_byte,
    input  logic [31:0]   box_result,
    output logic [31:0]   result,
    output logic [CW-1:0] byte_count,
    output logic          busy,
    output logic          done,
    output logic          stall_err
);

    localparam int TOTAL = WIDTH * HEIGHT * BPP;

    if (TOTAL > (2 ** CW) - 1) begin : g_total_too_big
        $error("bbox_frame_ctrl: TOTAL does not fit in CW bits");
    end
    if (STALL_CYCLES < 1) begin : g_stall_bad
        $error("bbox_frame_ctrl: STALL_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
`ifdef BBOX_STALL_TIMEOUT_EN
        , S_ERR  = 3'd5
`endif
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          abort_clr;
    logic          active;
    logic          abort_hit;
    logic          transfer;
    logic          last_byte;
    logic [CW-1:0] count;
    logic [31:0]   result_r;

    assign active    = (state == S_CLEAR) || (state == S_STREAM) || (state == S_FLUSH);
    assign abort_hit = abort && active;
    assign transfer  = s_valid && (state == S_STREAM);
    assign last_byte = transfer && (count == CW'(TOTAL - 1));

`ifdef BBOX_STALL_TIMEOUT_EN
    localparam int IW = $clog2(STALL_CYCLES + 1);
    logic [IW-1:0] idle_cnt;
    logic          stall_hit;

    assign stall_hit = (state == S_STREAM) && !s_valid && (idle_cnt == IW'(STALL_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || state != S_STREAM || s_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            abort_clr <= 1'b0;
            count     <= '0;
            result_r  <= '0;
        end else begin
            state     <= state_next;
            abort_clr <= abort_hit;
            if (state == S_CLEAR) begin
                count <= '0;
            end else if (transfer && !abort) begin
                count <= count + 1'b1;
            end
            // Engine output has had a full idle cycle to settle by the end of FLUSH.
            if (state == S_FLUSH && !abort) begin
                result_r <= box_result;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start && !abort) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_STREAM;
            S_STREAM: begin
                if (last_byte) begin
                    state_next = S_FLUSH;
                end
`ifdef BBOX_STALL_TIMEOUT_EN
                else if (stall_hit) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_FLUSH:  state_next = S_DONE;
            S_DONE:   if (start && !abort) state_next = S_CLEAR;
`ifdef BBOX_STALL_TIMEOUT_EN
            S_ERR: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next = S_CLEAR;
                end
            end
`endif
            default:  state_next = S_IDLE;
        endcase
        if (abort_hit) begin
            state_next = S_IDLE;
        end
    end

    assign s_ready    = (state == S_STREAM);
    assign box_wr_en  = transfer;
    assign box_byte   = s_data;
    assign box_clr    = (state == S_CLEAR) || abort_clr;
    assign busy       = active;
    assign done       = (state == S_DONE);
    assign result     = result_r;
    assign byte_count = count;
`ifdef BBOX_STALL_TIMEOUT_EN
    assign stall_err  = (state == S_ERR);
`else
    assign stall_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// tb/tb_bbox_frame_ctrl.sv - scoreboard bench for bbox_frame_ctrl on a reduced 10x10x3 frame
module tb_bbox_frame_ctrl;

    localparam int WIDTH  = 10;
    localparam int HEIGHT = 10;
    localparam int BPP    = 3;
    localparam int TOTAL  = 300;
    localparam int CW     = 9;
    localparam int STALL  = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          box_clr;
    logic          box_wr_en;
    logic [7:0]    box_byte;
    logic [31:0]   box_result = 32'h0;
    logic [31:0]   result;
    logic [CW-1:0] byte_count;
    logic          busy;
    logic          done;
    logic          stall_err;

    bbox_frame_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(BPP), .CW(CW), .STALL_CYCLES(STALL)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .box_clr(box_clr), .box_wr_en(box_wr_en), .box_byte(box_byte),
        .box_result(box_result), .result(result), .byte_count(byte_count),
        .busy(busy), .done(done), .stall_err(stall_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_err = 0;
    int idx = 0;
    logic [CW+7:0] exp_wr_q[$];
    logic [31:0]   exp_res_q[$];
    logic [CW+7:0] wr_e;
    logic          done_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bval(input int i, input int f);
        return 8'((i * 7 + f * 31 + 3) & 255);
    endfunction

    // Monitor: every engine strobe and every rising done is matched against the scoreboard.
    always @(negedge CLOCK_50) begin
        if (box_wr_en) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                wr_e = exp_wr_q.pop_front();
                chk("wr_byte", 32'(box_byte), 32'(wr_e[7:0]));
                chk("wr_count", 32'(byte_count), 32'(wr_e[CW+7:8]));
            end
        end
        if (done && !done_q) begin
            if (exp_res_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("done_result", result, exp_res_q.pop_front());
                chk("done_count", 32'(byte_count), 32'(TOTAL));
            end
        end
        done_q <= done;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_box_clr"}, 32'(box_clr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_stall_err"}, 32'(stall_err), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    endtask

    task automatic start_frame();
        idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_box_clr", 32'(box_clr), 32'd1);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_done", 32'(done), 32'd0);
        chk("clear_s_ready", 32'(s_ready), 32'd0);
        tick();
    endtask

    task automatic stream(input int upto, input bit rnd, input int start_at, input int f);
        bit pulsed = 0;
        bit v;
        int idle_run = 0;
        while (idx < upto) begin
            box_result = 32'hDEAD_0000 | 32'(idx);
            v = rnd ? ($urandom_range(0, 1) == 1 || idle_run >= 3) : 1'b1;
            start = (idx == start_at && !pulsed);
            if (v) begin
                s_valid = 1'b1;
                s_data = bval(idx, f);
                exp_wr_q.push_back({CW'(idx), s_data});
                idx++;
                idle_run = 0;
            end else begin
                s_valid = 1'b0;
                s_data = 8'h5A;
                idle_run++;
            end
            tick();
            if (start) begin
                pulsed = 1;
                start = 1'b0;
                chk("start_ignored_clr", 32'(box_clr), 32'd0);
                chk("start_ignored_busy", 32'(busy), 32'd1);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [31:0] r);
        box_result = r;
        exp_res_q.push_back(r);
        s_valid = 1'b1;
        s_data = 8'hEE;
        chk("flush_s_ready", 32'(s_ready), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        tick();
        box_result = ~r;
        chk("done_after_2", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        tick();
        tick();
        s_valid = 1'b0;
        chk("done_result_hold", result, r);
        chk("done_count_hold", 32'(byte_count), 32'(TOTAL));
        chk("done_s_ready", 32'(s_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        tick();
        tick();
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick();
        check_reset_vals("idle");

        // Frame 1: continuous valid
        start_frame();
        stream(TOTAL, 1'b0, -1, 1);
        finish_frame(32'h0A14_1E28);

        // Frame 2: random valid, start pulse in STREAM ignored, start from DONE
        start_frame();
        stream(TOTAL, 1'b1, 50, 2);
        finish_frame(32'h0305_6263);

        // Frame 3: abort mid-stream
        start_frame();
        stream(100, 1'b0, -1, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_box_clr", 32'(box_clr), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'h0305_6263);
        chk("abort_count", 32'(byte_count), 32'd100);
        tick();
        chk("abort_clr_1cyc", 32'(box_clr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_noclr", 32'(box_clr), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // Frame 4: reset mid-stream
        start_frame();
        stream(120, 1'b0, -1, 4);
        reset_n = 1'b0;
        tick();
        check_reset_vals("midreset");
        reset_n = 1'b1;
        tick();

        // Frame 5: long idle gap mid-frame
        start_frame();
        stream(200, 1'b0, -1, 5);
`ifdef BBOX_STALL_TIMEOUT_EN
        repeat (STALL - 1) tick();
        chk("stall_not_yet", 32'(stall_err), 32'd0);
        tick();
        chk("stall_err", 32'(stall_err), 32'd1);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        chk("stall_result", result, 32'd0);
        start_frame();
        stream(TOTAL, 1'b0, -1, 6);
`else
        repeat (40) tick();
        chk("gap_stall_err", 32'(stall_err), 32'd0);
        chk("gap_s_ready", 32'(s_ready), 32'd1);
        chk("gap_count", 32'(byte_count), 32'd200);
        stream(TOTAL, 1'b0, -1, 5);
`endif
        finish_frame(32'h0011_2233);

        tick();
        chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
